ip_tx: RTL and testbench

- IPv4 transmit path between the upper layer (UDP/ICMP) and the MAC TX path.
- Accepts a payload stream on a 64-bit AXIS bus, with header fields in tuser.
- Prepends a 20-byte IPv4 header, including a computed header checksum.
- Emits the realigned packet to the MAC layer with EtherType 0x0800 in tuser.

---
 rtl/ip_tx_pkg.sv | 34 +++
 rtl/ip_hdr_checksum.sv | 62 ++++++
 rtl/ip_tx.sv | 217 +++++++++++++++++++++
 tb/tb_ip_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ip_tx_pkg
//  Description : Shared constants and types for the IPv4 transmit path.
//                The upper-layer user field is described as a packed struct.
//                Its bit offsets, MSB first, are:
//                  [55:40] payload_len   [39:37] flags   [36:29] protocol
//                  [28:16] frag offset   [15:0]  identification
//  Revision    : 1.0  initial release
// ============================================================================
package ip_tx_pkg;

    localparam logic [7:0]  c_IP_VER_IHL     = 8'h45;
    localparam logic [15:0] c_ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] c_IP_HDR_LEN     = 16'd20;

    typedef struct packed {
        logic [15:0] payload_len;
        logic [2:0]  flags;
        logic [7:0]  protocol;
        logic [12:0] offset;
        logic [15:0] id;
    } upper_user_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_TAIL = 3'd4
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/ip_hdr_checksum.sv
`default_nettype none
// ============================================================================
//  Module      : ip_hdr_checksum
//  Description : Two-stage IPv4 header checksum. Stage 1 registers a 20-bit
//                sum of the nine header words (checksum field excluded);
//                stage 2 folds the carries twice and inverts.
//                Result appears two clocks after the inputs are presented.
//  Ports       : i_clk, i_rst        clock, async active-high reset
//                i_total_len         IP total length
//                i_id                identification
//                i_flags_offset      {flags, fragment offset}
//                i_ttl_proto         {TTL, protocol}
//                i_src_ip, i_dst_ip  addresses
//                o_checksum          header checksum
//  Revision    : 1.0  initial release
// ============================================================================
module ip_hdr_checksum
    import ip_tx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_total_len,
    input  logic [15:0] i_id,
    input  logic [15:0] i_flags_offset,
    input  logic [15:0] i_ttl_proto,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    output logic [15:0] o_checksum
);

    logic [19:0] sum_d, sum_q;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [15:0] csum_q;

    always_comb begin
        sum_d = 20'({c_IP_VER_IHL, 8'h00}) + 20'(i_total_len) + 20'(i_id)
              + 20'(i_flags_offset) + 20'(i_ttl_proto)
              + 20'(i_src_ip[31:16]) + 20'(i_src_ip[15:0])
              + 20'(i_dst_ip[31:16]) + 20'(i_dst_ip[15:0]);
    end

    // Nine 16-bit words never exceed 20 bits, so two folds always suffice.
    always_comb begin
        w_fold1 = 17'(sum_q[15:0]) + 17'(sum_q[19:16]);
        w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q  <= '0;
            csum_q <= '0;
        end else begin
            sum_q  <= sum_d;
            csum_q <= ~w_fold2;
        end
    end

    assign o_checksum = csum_q;

endmodule
`default_nettype wire

// File: rtl/ip_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ip_tx
//  Description : IPv4 transmit path. Prepends a 20-byte IPv4 header to the
//                upper-layer payload stream and realigns the payload by four
//                bytes onto the 64-bit MAC bus.
//  Ports       : i_clk, i_rst                clock, async active-high reset
//                i_dynamic_*                 runtime src/dst IP and dst MAC load
//                s_axis_upper_*              payload in, header fields in user
//                m_axis_mac_*                IP packet out, no backpressure
//  Revision    : 1.0  initial release
// ============================================================================
module ip_tx
    import ip_tx_pkg::*;
#(
    parameter logic [31:0] P_SRC_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd99},
    parameter logic [31:0] P_DST_IP_ADDR  = {8'd192, 8'd168, 8'd100, 8'd100},
    parameter logic [47:0] P_DST_MAC_ADDR = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [7:0]  P_TTL          = 8'd64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dynamic_src_ip,
    input  logic        i_dynamic_src_valid,
    input  logic [31:0] i_dynamic_dst_ip,
    input  logic        i_dynamic_dst_valid,
    input  logic [47:0] i_dynamic_dst_mac,
    input  logic        i_dynamic_dst_mac_valid,
    input  logic [63:0] s_axis_upper_data,
    input  logic [55:0] s_axis_upper_user,
    input  logic [7:0]  s_axis_upper_keep,
    input  logic        s_axis_upper_last,
    input  logic        s_axis_upper_valid,
    output logic        s_axis_upper_ready,
    output logic [63:0] m_axis_mac_data,
    output logic [79:0] m_axis_mac_user,
    output logic [7:0]  m_axis_mac_keep,
    output logic        m_axis_mac_last,
    output logic        m_axis_mac_valid
);

    logic [31:0] src_ip_q, dst_ip_q, snap_src_q, snap_dst_q;
    logic [47:0] dst_mac_q, snap_mac_q;
    upper_user_t snap_user_q;
    tx_state_e   state_q, state_d;
    logic        data_first_q, data_first_d;
    logic        ready_q, ready_d;

    // Payload delay line: three full stages, then only the lower half of the
    // oldest beat is kept, since that is all the realigned output needs.
    logic [2:0][63:0] dly_data_q;
    logic [2:0][7:0]  dly_keep_q;
    logic [2:0]       dly_last_q;
    logic [31:0]      tail_data_q;
    logic [3:0]       tail_keep_q;

    logic [63:0] m_data_q, m_data_d;
    logic [79:0] m_user_q, m_user_d;
    logic [7:0]  m_keep_q, m_keep_d;
    logic        m_last_q, m_last_d, m_valid_q, m_valid_d;

    logic        w_accept, w_start;
    upper_user_t w_user;
    logic [15:0] w_total_len, w_snap_total_len, w_checksum;
    logic [63:0] w_in_masked;

    assign w_accept         = s_axis_upper_valid & ready_q;
    assign w_start          = w_accept & (state_q == ST_IDLE);
    assign w_user           = upper_user_t'(s_axis_upper_user);
    assign w_total_len      = w_user.payload_len + c_IP_HDR_LEN;
    assign w_snap_total_len = snap_user_q.payload_len + c_IP_HDR_LEN;

    always_comb begin
        w_in_masked = '0;
        for (int b = 0; b < 8; b++) begin
            if (s_axis_upper_keep[b]) w_in_masked[8*b +: 8] = s_axis_upper_data[8*b +: 8];
        end
    end

    // Fed from the live first beat so the result lands exactly when W1 is built.
    ip_hdr_checksum u_csum (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_total_len    (w_total_len),
        .i_id           (w_user.id),
        .i_flags_offset ({w_user.flags, w_user.offset}),
        .i_ttl_proto    ({P_TTL, w_user.protocol}),
        .i_src_ip       (src_ip_q),
        .i_dst_ip       (dst_ip_q),
        .o_checksum     (w_checksum)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            src_ip_q    <= P_SRC_IP_ADDR;
            dst_ip_q    <= P_DST_IP_ADDR;
            dst_mac_q   <= P_DST_MAC_ADDR;
            snap_src_q  <= '0;
            snap_dst_q  <= '0;
            snap_mac_q  <= '0;
            snap_user_q <= '0;
            dly_data_q  <= '0;
            dly_keep_q  <= '0;
            dly_last_q  <= '0;
            tail_data_q <= '0;
            tail_keep_q <= '0;
        end else begin
            if (i_dynamic_src_valid)     src_ip_q  <= i_dynamic_src_ip;
            if (i_dynamic_dst_valid)     dst_ip_q  <= i_dynamic_dst_ip;
            if (i_dynamic_dst_mac_valid) dst_mac_q <= i_dynamic_dst_mac;
            if (w_start) begin
                snap_src_q  <= src_ip_q;
                snap_dst_q  <= dst_ip_q;
                snap_mac_q  <= dst_mac_q;
                snap_user_q <= w_user;
            end
            dly_data_q[0] <= w_accept ? w_in_masked : '0;
            dly_keep_q[0] <= w_accept ? s_axis_upper_keep : '0;
            dly_last_q[0] <= w_accept & s_axis_upper_last;
            dly_data_q[2:1] <= dly_data_q[1:0];
            dly_keep_q[2:1] <= dly_keep_q[1:0];
            dly_last_q[2:1] <= dly_last_q[1:0];
            tail_data_q <= dly_data_q[2][31:0];
            tail_keep_q <= dly_keep_q[2][3:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        data_first_d = data_first_q;
        m_valid_d    = 1'b0;
        m_last_d     = 1'b0;
        m_data_d     = '0;
        m_keep_d     = 8'hFF;
        m_user_d     = m_user_q;
        case (state_q)
            ST_IDLE: begin
                if (w_start) state_d = ST_HDR0;
            end
            ST_HDR0: begin
                m_valid_d = 1'b1;
                m_data_d  = {c_IP_VER_IHL, 8'h00, w_snap_total_len, snap_user_q.id,
                             snap_user_q.flags, snap_user_q.offset};
                m_user_d  = {w_snap_total_len, snap_mac_q, c_ETHERTYPE_IPV4};
                state_d   = ST_HDR1;
            end
            ST_HDR1: begin
                m_valid_d    = 1'b1;
                m_data_d     = {P_TTL, snap_user_q.protocol, w_checksum, snap_src_q};
                data_first_d = 1'b1;
                state_d      = ST_DATA;
            end
            ST_DATA: begin
                // The first data word borrows its upper half from the dst IP.
                m_valid_d    = 1'b1;
                data_first_d = 1'b0;
                m_data_d     = {(data_first_q ? snap_dst_q : tail_data_q),
                                dly_data_q[2][63:32]};
                if (dly_last_q[2]) begin
                    if (dly_keep_q[2] <= 8'hF0) begin
                        m_last_d = 1'b1;
                        m_keep_d = {4'hF, dly_keep_q[2][7:4]};
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                m_valid_d = 1'b1;
                m_last_d  = 1'b1;
                m_data_d  = {tail_data_q, 32'h0};
                m_keep_d  = {tail_keep_q, 4'h0};
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Closed after the final input beat; reopened once the packet has drained.
    always_comb begin
        ready_d = ready_q;
        if (w_accept && s_axis_upper_last) ready_d = 1'b0;
        else if (m_last_q)                 ready_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            data_first_q <= 1'b0;
            ready_q      <= 1'b1;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= 8'hFF;
            m_user_q     <= '0;
        end else begin
            state_q      <= state_d;
            data_first_q <= data_first_d;
            ready_q      <= ready_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_user_q     <= m_user_d;
        end
    end

    assign s_axis_upper_ready = ready_q;
    assign m_axis_mac_data    = m_data_q;
    assign m_axis_mac_user    = m_user_q;
    assign m_axis_mac_keep    = m_keep_q;
    assign m_axis_mac_last    = m_last_q;
    assign m_axis_mac_valid   = m_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ip_tx
//  Description : Directed testbench for ip_tx. A byte-level packet model
//                builds the expected output words; one process compares
//                every output cycle against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ip_tx;

    localparam logic [31:0] C_SRC = 32'hC0A86463;
    localparam logic [31:0] C_DST = 32'hC0A86464;
    localparam logic [47:0] C_MAC = 48'hFFFFFFFFFFFF;
    localparam logic [7:0]  C_TTL = 8'd64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dyn_src_ip = '0, dyn_dst_ip = '0;
    logic [47:0] dyn_mac = '0;
    logic        dyn_src_valid = 1'b0, dyn_dst_valid = 1'b0, dyn_mac_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic [55:0] s_user = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0, s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] m_data;
    logic [79:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last, m_valid;

    ip_tx #(
        .P_SRC_IP_ADDR (C_SRC),
        .P_DST_IP_ADDR (C_DST),
        .P_DST_MAC_ADDR(C_MAC),
        .P_TTL         (C_TTL)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .i_dynamic_src_ip       (dyn_src_ip),
        .i_dynamic_src_valid    (dyn_src_valid),
        .i_dynamic_dst_ip       (dyn_dst_ip),
        .i_dynamic_dst_valid    (dyn_dst_valid),
        .i_dynamic_dst_mac      (dyn_mac),
        .i_dynamic_dst_mac_valid(dyn_mac_valid),
        .s_axis_upper_data      (s_data),
        .s_axis_upper_user      (s_user),
        .s_axis_upper_keep      (s_keep),
        .s_axis_upper_last      (s_last),
        .s_axis_upper_valid     (s_valid),
        .s_axis_upper_ready     (s_ready),
        .m_axis_mac_data        (m_data),
        .m_axis_mac_user        (m_user),
        .m_axis_mac_keep        (m_keep),
        .m_axis_mac_last        (m_last),
        .m_axis_mac_valid       (m_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [79:0] u;
        int          c;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pay[$];
    logic [31:0] mdl_src = C_SRC, mdl_dst = C_DST;
    logic [47:0] mdl_mac = C_MAC;
    int          prev_last_cyc = -1;
    int          total = 0, bad = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    // Expected packet = 20-byte header followed by the payload bytes, cut into
    // 8-byte words; the first word is due the cycle after the first accept.
    task automatic push_model(input logic [55:0] u, input int e);
        logic [15:0] plen, tl, ck;
        logic [15:0] w[9];
        int          sum, nbytes, nout;
        logic [7:0]  by[$];
        exp_t        x;
        plen = u[55:40];
        tl   = plen + 16'd20;
        w[0] = 16'h4500;          w[1] = tl;               w[2] = u[15:0];
        w[3] = {u[39:37], u[28:16]};  w[4] = {C_TTL, u[36:29]};
        w[5] = mdl_src[31:16];    w[6] = mdl_src[15:0];
        w[7] = mdl_dst[31:16];    w[8] = mdl_dst[15:0];
        sum = 0;
        for (int i = 0; i < 9; i++) sum += int'(w[i]);
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        ck = ~sum[15:0];
        for (int i = 0; i < 5; i++) begin by.push_back(w[i][15:8]); by.push_back(w[i][7:0]); end
        by.push_back(ck[15:8]); by.push_back(ck[7:0]);
        for (int i = 5; i < 9; i++) begin by.push_back(w[i][15:8]); by.push_back(w[i][7:0]); end
        for (int i = 0; i < int'(plen); i++) by.push_back(pay[i]);
        nbytes = by.size();
        nout   = (nbytes + 7) / 8;
        for (int i = 0; i < nout; i++) begin
            x.d = '0; x.k = '0;
            for (int j = 0; j < 8; j++) begin
                if (i*8 + j < nbytes) begin
                    x.d[63 - 8*j -: 8] = by[i*8 + j];
                    x.k[7 - j] = 1'b1;
                end
            end
            x.l = (i == nout - 1);
            x.u = {tl, mdl_mac, 16'h0800};
            x.c = e + 1 + i;
            exp_q.push_back(x);
        end
        prev_last_cyc = e + nout;
    endtask

    task automatic send(input logic [55:0] u, input int len, input int upd_beat,
                        input logic [31:0] new_dst);
        int nb, guard;
        bit waited;
        logic [63:0] d;
        logic [7:0]  k;
        nb = (len + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = '0; k = '0;
            for (int j = 0; j < 8; j++) begin
                if (b*8 + j < len) begin d[63 - 8*j -: 8] = pay[b*8 + j]; k[7 - j] = 1'b1; end
            end
            s_data = d; s_keep = k; s_last = (b == nb - 1); s_user = u; s_valid = 1'b1;
            dyn_dst_valid = (b == upd_beat); dyn_dst_ip = new_dst;
            if (b == 0) begin
                waited = !s_ready;
                guard  = 0;
                while (!s_ready && guard < 200) begin @(posedge clk); #1; guard++; end
                if (!s_ready) begin
                    chk("ready_timeout", {79'h0, s_ready}, 80'h1);
                    s_valid = 1'b0;
                    return;
                end
                if (waited && prev_last_cyc >= 0) chk("ready_rise_cyc", cyc, prev_last_cyc + 1);
            end else begin
                chk("ready_mid_pkt", {79'h0, s_ready}, 80'h1);
            end
            @(posedge clk); #1;
            if (b == 0) push_model(u, cyc);
            if (b == upd_beat) mdl_dst = new_dst;
        end
        s_valid = 1'b0; s_last = 1'b0; dyn_dst_valid = 1'b0;
        chk("ready_after_last", {79'h0, s_ready}, 80'h0);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin @(posedge clk); #1; guard++; end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_values();
        chk("rst_valid", {79'h0, m_valid}, 80'h0);
        chk("rst_last",  {79'h0, m_last},  80'h0);
        chk("rst_keep",  {72'h0, m_keep},  80'hFF);
        chk("rst_data",  {16'h0, m_data},  80'h0);
        chk("rst_user",  m_user,           80'h0);
        chk("rst_ready", {79'h0, s_ready}, 80'h1);
    endtask

    task automatic fill_pay(input int len, input int seed);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'(i * 13 + seed * 29 + 1));
    endtask

    always @(negedge clk) begin : cmp
        logic ev;
        exp_t e;
        if (!rst) begin
            ev = (exp_q.size() > 0) && (exp_q[0].c == cyc);
            if (m_valid || ev) chk("out_valid", {79'h0, m_valid}, {79'h0, ev});
            if (ev) begin
                e = exp_q.pop_front();
                if (m_valid) begin
                    chk("out_data", {16'h0, m_data}, {16'h0, e.d});
                    chk("out_keep", {72'h0, m_keep}, {72'h0, e.k});
                    chk("out_last", {79'h0, m_last}, {79'h0, e.l});
                    chk("out_user", m_user, e.u);
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic 12-byte packet with hand-computed words
        pay = {8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
               8'h88, 8'h99, 8'hAA, 8'hBB};
        send({16'd12, 3'b010, 8'h11, 13'd0, 16'h0001}, 12, -1, 32'h0);
        chk("pin1_n",  exp_q.size(), 4);
        chk("pin1_w0", {16'h0, exp_q[0].d}, {16'h0, 64'h4500002000014000});
        chk("pin1_w1", {16'h0, exp_q[1].d}, {16'h0, 64'h4011F0B3C0A86463});
        chk("pin1_w2", {16'h0, exp_q[2].d}, {16'h0, 64'hC0A8646400112233});
        chk("pin1_w3", {16'h0, exp_q[3].d}, {16'h0, 64'h445566778899AABB});
        chk("pin1_k3", {72'h0, exp_q[3].k}, 80'hFF);
        chk("pin1_u",  exp_q[0].u, {16'h0020, 48'hFFFFFFFFFFFF, 16'h0800});
        wait_idle();

        // 8-byte single-beat packet
        pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        send({16'd8, 3'b000, 8'h01, 13'd0, 16'h1234}, 8, -1, 32'h0);
        chk("pin2_n",  exp_q.size(), 4);
        chk("pin2_w3", {16'h0, exp_q[3].d}, {16'h0, 64'hCAFEF00D00000000});
        chk("pin2_k3", {72'h0, exp_q[3].k}, 80'hF0);
        chk("pin2_tl", {64'h0, exp_q[0].u[79:64]}, 80'h001C);
        wait_idle();

        // Keep sweep on the last input beat: 80 .. FF
        for (int n = 1; n <= 8; n++) begin
            fill_pay(8 + n, n);
            send({16'(8 + n), 3'b000, 8'h11, 13'(n), 16'(n * 3)}, 8 + n, -1, 32'h0);
            wait_idle();
        end

        // Back-to-back: second packet waits with valid held while ready is low
        fill_pay(20, 9);
        send({16'd20, 3'b010, 8'h06, 13'd0, 16'hAAAA}, 20, -1, 32'h0);
        fill_pay(5, 10);
        send({16'd5, 3'b000, 8'h01, 13'd7, 16'hBBBB}, 5, -1, 32'h0);
        wait_idle();

        // Dynamic dst update one cycle into packet A
        fill_pay(16, 11);
        send({16'd16, 3'b000, 8'h11, 13'd0, 16'h0A0A}, 16, 1, 32'h0A000007);
        chk("pinA_dst", {48'h0, exp_q[2].d[63:32]}, {48'h0, 32'hC0A86464});
        wait_idle();
        dyn_src_ip = 32'h0A000001; dyn_src_valid = 1'b1;
        dyn_mac = 48'h020000000001; dyn_mac_valid = 1'b1;
        @(posedge clk); #1;
        dyn_src_valid = 1'b0; dyn_mac_valid = 1'b0;
        mdl_src = 32'h0A000001; mdl_mac = 48'h020000000001;
        fill_pay(13, 12);
        send({16'd13, 3'b000, 8'h11, 13'd0, 16'h0B0B}, 13, -1, 32'h0);
        chk("pinB_dst", {48'h0, exp_q[2].d[63:32]}, {48'h0, 32'h0A000007});
        wait_idle();

        // Reset while W2 is on the bus
        fill_pay(24, 13);
        send({16'd24, 3'b000, 8'h11, 13'd0, 16'h0C0C}, 24, -1, 32'h0);
        @(posedge clk); #2;
        chk("w2_before_rst", {79'h0, m_valid}, 80'h1);
        chk("w2_data_before_rst", {16'h0, m_data}, {16'h0, exp_q[0].d});
        rst = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        mdl_src = C_SRC; mdl_dst = C_DST; mdl_mac = C_MAC;
        prev_last_cyc = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_pay(12, 14);
        send({16'd12, 3'b010, 8'h11, 13'd0, 16'h0D0D}, 12, -1, 32'h0);
        wait_idle();

        repeat (4) @(posedge clk);
        #1;
        chk("no_leftover", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
